fp32_mul_norm_round: RTL and testbench

- Downstream stage of the radix-8 MBE mantissa multiplier.
- Consumes the 48-bit significand product plus sign/exponent/class side-band from the FP32 unpack logic.
- Normalises, rounds (RNE), handles exponent overflow/underflow and IEEE special cases, and emits a packed FP32 result with exception flags.
- Two-stage valid/ready pipeline; sits between the multiplier array and the FPU writeback.

---
 rtl/booth_pkg.sv | 35 +++
 rtl/fp32_mul_norm_round_if.sv | 33 +++
 rtl/fp32_mul_norm_round_rne.sv | 39 +++
 rtl/fp32_mul_norm_round.sv | 148 ++++++++++++++
 tb/tb_fp32_mul_norm_round.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the FP32 multiplier datapath.
package booth_pkg;

  localparam int NBIT_MANTISSA = 23;
  localparam int NBIT_EXP      = 8;
  localparam int EXP_BIAS      = 127;
  localparam int NBIT_PRODUCT  = 2 * (NBIT_MANTISSA + 1);
  localparam int EXP_MAX       = 255;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Operand class from the unpack logic; denormals arrive already flushed to ZERO.
  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } t_fp_class;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } t_fp_flags;

  // Special-case outcome decided in stage 1 and carried to the packer.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_ZERO = 2'd1,
    SP_INF  = 2'd2,
    SP_QNAN = 2'd3
  } t_fp_special;

endpackage

// File: rtl/fp32_mul_norm_round_if.sv
// Upstream/downstream bus of the normalise-and-round stage.
// Handshake: a beat moves on a rising clk edge where valid and ready are both 1;
// a producer holds valid and payload steady until that edge, and ready may
// depend combinationally on the consumer's downstream ready.
interface fp32_mul_norm_round_if;
  import booth_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [NBIT_PRODUCT-1:0] in_product;
  logic                    in_sign;
  logic [NBIT_EXP-1:0]     in_exp_x;
  logic [NBIT_EXP-1:0]     in_exp_y;
  t_fp_class               in_class_x;
  t_fp_class               in_class_y;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  t_fp_flags               out_flags;

  modport master (
    output in_valid, in_product, in_sign, in_exp_x, in_exp_y, in_class_x, in_class_y,
    output out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_product, in_sign, in_exp_x, in_exp_y, in_class_x, in_class_y,
    input  out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp32_mul_norm_round_rne.sv
// Combinational round-to-nearest-even, exponent carry and range check (flush to zero).
module fp_round_rne
  import booth_pkg::*;
(
  input  logic                     sign,
  input  logic [9:0]               exp_in,
  input  logic [NBIT_MANTISSA-1:0] mant_in,
  input  logic                     guard,
  input  logic                     sticky,
  output logic [31:0]              result,
  output t_fp_flags                flags
);

  logic                     round_up;
  logic                     carry;
  logic [NBIT_MANTISSA-1:0] mant_rnd;
  logic [9:0]               exp_rnd;

  // Round, fold the mantissa carry into the exponent, then clamp to inf / zero.
  always_comb begin
    round_up          = guard & (mant_in[0] | sticky);
    {carry, mant_rnd} = {1'b0, mant_in} + (NBIT_MANTISSA + 1)'(round_up);
    exp_rnd           = exp_in + 10'(carry);
    flags             = '0;
    flags.inexact     = guard | sticky;
    if ($signed(exp_rnd) >= $signed(10'(EXP_MAX))) begin
      result         = {sign, 8'hFF, 23'd0};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end else if ($signed(exp_rnd) <= 10'sd0) begin
      result          = {sign, 8'h00, 23'd0};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end else begin
      result = {sign, exp_rnd[7:0], mant_rnd};
    end
  end

endmodule

// File: rtl/fp32_mul_norm_round.sv
// Two-stage normalise / RNE round / pack stage after the mantissa multiplier.
module fp32_mul_norm_round
  import booth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fp32_mul_norm_round_if.slave bus
);

  logic s1_en, s2_en;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_sign_q, s1_sign_d;
  logic [9:0]               s1_exp_q, s1_exp_d;
  logic [NBIT_MANTISSA-1:0] s1_mant_q, s1_mant_d;
  logic                     s1_g_q, s1_g_d;
  logic                     s1_s_q, s1_s_d;
  t_fp_special              s1_special_q, s1_special_d;
  logic                     s1_invalid_q, s1_invalid_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] out_result_q, out_result_d;
  t_fp_flags   out_flags_q, out_flags_d;

  logic [9:0]  exp_sum;
  logic [31:0] rnd_result;
  t_fp_flags   rnd_flags;

  // Backpressure chain: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_en        = !s2_valid_q | bus.out_ready;
    s1_en        = !s1_valid_q | s2_en;
    bus.in_ready = s1_en;
  end

  // Stage 1: exponent sum, leading-one normalisation, special-case decode.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_mant_d    = s1_mant_q;
    s1_g_d       = s1_g_q;
    s1_s_d       = s1_s_q;
    s1_special_d = s1_special_q;
    s1_invalid_d = s1_invalid_q;
    exp_sum      = 10'(bus.in_exp_x) + 10'(bus.in_exp_y) - 10'(EXP_BIAS);
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d    = bus.in_sign;
        s1_invalid_d = 1'b0;
        if (bus.in_product[47]) begin
          s1_mant_d = bus.in_product[46:24];
          s1_g_d    = bus.in_product[23];
          s1_s_d    = |bus.in_product[22:0];
          s1_exp_d  = exp_sum + 10'd1;
        end else begin
          s1_mant_d = bus.in_product[45:23];
          s1_g_d    = bus.in_product[22];
          s1_s_d    = |bus.in_product[21:0];
          s1_exp_d  = exp_sum;
        end
        if (bus.in_class_x == FP_NAN || bus.in_class_y == FP_NAN) begin
          s1_special_d = SP_QNAN;
        end else if ((bus.in_class_x == FP_INF && bus.in_class_y == FP_ZERO) ||
                     (bus.in_class_x == FP_ZERO && bus.in_class_y == FP_INF)) begin
          s1_special_d = SP_QNAN;
          s1_invalid_d = 1'b1;
        end else if (bus.in_class_x == FP_INF || bus.in_class_y == FP_INF) begin
          s1_special_d = SP_INF;
        end else if (bus.in_class_x == FP_ZERO || bus.in_class_y == FP_ZERO) begin
          s1_special_d = SP_ZERO;
        end else begin
          s1_special_d = SP_NONE;
        end
      end
    end
  end

  fp_round_rne u_round (
    .sign    (s1_sign_q),
    .exp_in  (s1_exp_q),
    .mant_in (s1_mant_q),
    .guard   (s1_g_q),
    .sticky  (s1_s_q),
    .result  (rnd_result),
    .flags   (rnd_flags)
  );

  // Stage 2: pick the special result over the rounded one and hold while stalled.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_flags_d = '0;
        case (s1_special_q)
          SP_QNAN: begin
            out_result_d        = FP32_QNAN;
            out_flags_d.invalid = s1_invalid_q;
          end
          SP_INF:  out_result_d = {s1_sign_q, 8'hFF, 23'd0};
          SP_ZERO: out_result_d = {s1_sign_q, 31'd0};
          default: begin
            out_result_d = rnd_result;
            out_flags_d  = rnd_flags;
          end
        endcase
      end
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_g_q       <= 1'b0;
      s1_s_q       <= 1'b0;
      s1_special_q <= SP_NONE;
      s1_invalid_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_g_q       <= s1_g_d;
      s1_s_q       <= s1_s_d;
      s1_special_q <= s1_special_d;
      s1_invalid_q <= s1_invalid_d;
      s2_valid_q   <= s2_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Directed bench for fp32_mul_norm_round: hand-computed vectors, in-order scoreboard.
module tb_fp32_mul_norm_round;
  import booth_pkg::*;

  logic clk;
  logic rst_n;

  fp32_mul_norm_round_if bus ();

  fp32_mul_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  logic [35:0] held_val;
  bit          held_stall = 1'b0;

  // Monitor: compare every transferred result in order; check stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_stall && bus.out_valid)
        check("hold_stable", {bus.out_flags, bus.out_result}, held_val);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 36'(bus.out_valid), 36'd0);
        else check("result", {bus.out_flags, bus.out_result}, exp_q.pop_front());
      end
    end
    held_stall = rst_n && bus.out_valid && !bus.out_ready;
    held_val   = {bus.out_flags, bus.out_result};
  end

  // ---------------- driver ----------------
  task automatic send(input logic [47:0] p, input logic sg, input logic [7:0] ex,
                      input logic [7:0] ey, input t_fp_class cx, input t_fp_class cy,
                      input logic [35:0] expv);
    bit done = 1'b0;
    int budget = 0;
    bus.in_product = p;
    bus.in_sign    = sg;
    bus.in_exp_x   = ex;
    bus.in_exp_y   = ey;
    bus.in_class_x = cx;
    bus.in_class_y = cy;
    bus.in_valid   = 1'b1;
    while (!done && budget < 100) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      budget++;
    end
    if (done) exp_q.push_back(expv);
    else check("send_timeout", 36'(bus.in_ready), 36'd1);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 36'(exp_q.size()), 36'd0);
  endtask

  localparam logic [47:0] P_ONE = 48'h4000_0000_0000;
  localparam logic [47:0] P_ALL = 48'h7FFF_FFC0_0000;

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_sign    = 1'b0;
    bus.in_exp_x   = '0;
    bus.in_exp_y   = '0;
    bus.in_class_x = FP_ZERO;
    bus.in_class_y = FP_ZERO;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 36'(bus.out_valid), 36'd0);
    check("rst_out_word", {bus.out_flags, bus.out_result}, 36'd0);
    check("rst_in_ready", 36'(bus.in_ready), 36'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: 1.5*1.5 with an empty pipeline.
    send(48'h9000_0000_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h0, 32'h4010_0000});
    @(negedge clk);
    check("lat_cycle1", 36'(bus.out_valid), 36'd0);
    @(negedge clk);
    check("lat_cycle2", 36'(bus.out_valid), 36'd1);
    @(posedge clk);
    #1;

    // Arithmetic, rounding and range boundaries, back-to-back.
    send(48'h4000_00C0_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'h3F80_0002});
    send(48'h4000_0040_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'h3F80_0000});
    send(48'h4000_0040_0001, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'h3F80_0001});
    send(P_ALL,              1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'h4000_0000});
    send(P_ONE,              1'b0, 8'd200, 8'd200, FP_NORMAL, FP_NORMAL, {4'h5, 32'h7F80_0000});
    send(P_ALL,              1'b0, 8'd254, 8'd127, FP_NORMAL, FP_NORMAL, {4'h5, 32'h7F80_0000});
    send(P_ONE,              1'b0, 8'd10,  8'd10,  FP_NORMAL, FP_NORMAL, {4'h3, 32'h0000_0000});
    send(P_ONE,              1'b0, 8'd64,  8'd63,  FP_NORMAL, FP_NORMAL, {4'h3, 32'h0000_0000});
    send(P_ONE,              1'b0, 8'd64,  8'd64,  FP_NORMAL, FP_NORMAL, {4'h0, 32'h0080_0000});

    // Specials; product bits are junk on purpose.
    send(48'h1234_5678_9ABC, 1'b0, 8'd255, 8'd0,   FP_INF,    FP_ZERO,   {4'h8, 32'h7FC0_0000});
    send(48'h9000_0000_0000, 1'b1, 8'd255, 8'd127, FP_INF,    FP_NORMAL, {4'h0, 32'hFF80_0000});
    send(48'hFFFF_FFFF_FFFF, 1'b1, 8'd255, 8'd127, FP_NAN,    FP_NORMAL, {4'h0, 32'h7FC0_0000});
    send(48'h9000_0000_0000, 1'b1, 8'd0,   8'd127, FP_ZERO,   FP_NORMAL, {4'h0, 32'h8000_0000});
    send(48'h0,              1'b0, 8'd255, 8'd255, FP_INF,    FP_INF,    {4'h0, 32'h7F80_0000});
    drain();

    // Backpressure: two beats fill the pipe, the third waits for out_ready.
    bus.out_ready = 1'b0;
    send(48'h9000_0000_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h0, 32'h4010_0000});
    send(48'h4000_00C0_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'h3F80_0002});
    fork
      send(P_ONE, 1'b1, 8'd64, 8'd64, FP_NORMAL, FP_NORMAL, {4'h0, 32'h8080_0000});
      begin
        @(negedge clk);
        check("bp_in_ready_low", 36'(bus.in_ready), 36'd0);
        check("bp_out_valid", 36'(bus.out_valid), 36'd1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a stall discards everything in flight.
    bus.out_ready = 1'b0;
    send(48'h9000_0000_0000, 1'b0, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h0, 32'h4010_0000});
    send(P_ONE,              1'b0, 8'd200, 8'd200, FP_NORMAL, FP_NORMAL, {4'h5, 32'h7F80_0000});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 36'(bus.out_valid), 36'd0);
    check("midrst_out_word", {bus.out_flags, bus.out_result}, 36'd0);
    check("midrst_in_ready", 36'(bus.in_ready), 36'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 36'(bus.out_valid), 36'd0);
    end
    @(posedge clk);
    #1;

    // Pipeline still works after the flush.
    send(P_ALL, 1'b1, 8'd127, 8'd127, FP_NORMAL, FP_NORMAL, {4'h1, 32'hC000_0000});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
